// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types for the SRAM slave: transfer/size encodings,
// response codes and the slave data-phase state machine encoding.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_OKAY_DONE,
    ST_ERR1,
    ST_ERR2
  } sram_state_e;

endpackage

// File: rtl/ahb_sram_lane_mask.sv
// Byte-lane decode for a 32-bit little-endian AHB data bus.
// Ports:
//   hsize_i     transfer size (0=byte, 1=half, 2=word, >2 illegal)
//   addr_i      low two address bits
//   be_o        byte enables, bit n = hwdata[8n+7:8n]
//   align_err_o transfer is misaligned or has an unsupported size
module ahb_sram_lane_mask
  import ahb_pkg::*;
(
  input  logic [2:0] hsize_i,
  input  logic [1:0] addr_i,
  output logic [3:0] be_o,
  output logic       align_err_o
);

  always_comb begin
    be_o        = '0;
    align_err_o = 1'b0;
    case (hsize_i)
      HSIZE_BYTE: be_o = 4'b0001 << addr_i;
      HSIZE_HALF: begin
        be_o        = addr_i[1] ? 4'b1100 : 4'b0011;
        align_err_o = addr_i[0];
      end
      HSIZE_WORD: begin
        be_o        = 4'b1111;
        align_err_o = |addr_i;
      end
      default: align_err_o = 1'b1; // sizes wider than the bus
    endcase
  end

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave backed by a word-organised SRAM array.
// Every OKAY data phase is stretched by WAIT_STATES hreadyout-low cycles;
// illegal transfers get the two-cycle ERROR response and touch no memory.
// Ports:
//   hclk/hresetn          clock, async active-low reset
//   hsel..hready          AHB-Lite address phase + bus ready (hreadyin)
//   hwdata                write data (data phase)
//   hreadyout/hresp       slave ready and response
//   hrdata                read data, zero outside OKAY read completion
module ahb_lite_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [3:0]        hprot,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic [DATA_W-1:0] hrdata
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int LA_W  = IDX_W + 2;
  // One bit wider than haddr so a full-address-space array cannot wrap to 0.
  localparam logic [ADDR_W:0] BYTE_LIMIT = (ADDR_W+1)'(MEM_DEPTH * 4);
  localparam logic [3:0]      WS         = 4'(WAIT_STATES);

  sram_state_e       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [LA_W-1:0]   addr_q;
  logic              write_q;
  logic [3:0]        be_q;
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  logic [3:0] be_c;
  logic       align_err_c, illegal_c, capture, commit;
  logic       unused_ok;

  // Burst type and protection carry no meaning for this slave.
  assign unused_ok = ^{hburst, hprot, htrans[0]};

  ahb_sram_lane_mask u_mask (
    .hsize_i    (hsize),
    .addr_i     (haddr[1:0]),
    .be_o       (be_c),
    .align_err_o(align_err_c)
  );

  // NONSEQ/SEQ only; hreadyout is folded in so a master that keeps hready
  // high while we stall cannot overwrite the transfer in flight.
  assign capture   = hsel & hready & hreadyout & htrans[1];
  assign illegal_c = align_err_c | ({1'b0, haddr} >= BYTE_LIMIT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q <= 4'd1) state_d = ST_OKAY_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        // IDLE / OKAY_DONE / ERR2: any data phase finishes on this edge,
        // so a new capture chains straight in with no bubble.
        state_d = ST_IDLE;
        if (capture) begin
          if (illegal_c)     state_d = ST_ERR1;
          else if (WS == '0) state_d = ST_OKAY_DONE;
          else begin
            state_d = ST_WAIT;
            cnt_d   = WS;
          end
        end
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        addr_q  <= haddr[LA_W-1:0];
        write_q <= hwrite;
        be_q    <= be_c;
      end
    end
  end

  assign hreadyout = !(state_q == ST_WAIT || state_q == ST_ERR1);
  assign hresp     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign commit    = (state_q == ST_OKAY_DONE) && write_q;
  assign hrdata    = (state_q == ST_OKAY_DONE && !write_q) ? mem_q[addr_q[LA_W-1:2]] : '0;

  // Storage is not reset; commit is gated by the reset state register.
  always_ff @(posedge hclk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem_q[addr_q[LA_W-1:2]][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
- AHB-Lite slave with word-organised SRAM storage, programmable wait states and a two-cycle ERROR response.
- It is the DUT driven by the team's AHB-Lite testbench: the driver modport drives its inputs, and the monitor modport samples its outputs.
- Implements the AHB-Lite address/data pipeline, so a new address phase overlaps the current data phase.

Parameters:
- ADDR_W, 32, haddr width.
- DATA_W, 32, hwdata/hrdata width; only 32 is supported.
- MEM_DEPTH, 256, number of DATA_W words; legal byte range is 0 to MEM_DEPTH*4-1.
- WAIT_STATES, 1, hreadyout-low cycles inserted in every OKAY data phase (0..15).

Ports:
- hclk  in  1  system clock; all state changes on the rising edge.
- hresetn  in  1  asynchronous active-low reset.
- hsel  in  1  slave select.
- haddr  in  ADDR_W  byte address.
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hwrite  in  1  1=write, 0=read.
- hsize  in  3  0=byte, 1=half, 2=word; values above 2 are illegal.
- hburst  in  3  accepted and ignored; every beat is treated independently.
- hprot  in  4  ignored.
- hwdata  in  DATA_W  write data, valid in the data phase.
- hready  in  1  bus ready (hreadyin); a phase advances only when it is high.
- hreadyout  out  1  slave ready.
- hresp  out  1  0=OKAY, 1=ERROR.
- hrdata  out  DATA_W  read data.

Behaviour:
- Reset (async assert, sync release):
  - hreadyout=1, hresp=0, hrdata=0, FSM goes to IDLE, pending-transfer registers cleared.
  - Memory array is not reset.
- Address-phase capture: when hsel & hready & htrans[1], latch haddr, hwrite and hsize. Otherwise there is no pending transfer.
- IDLE/BUSY or unselected: the next data phase is zero-wait OKAY (hreadyout=1, hresp=0).
- Legality check at capture. Error if any of:
  - hsize>2;
  - misaligned address (half with haddr[0]=1, or word with haddr[1:0]!=0);
  - haddr >= MEM_DEPTH*4.
- FSM states: IDLE, WAIT, OKAY_DONE, ERR1, ERR2.
  - IDLE, legal capture: goes to WAIT and loads a counter with WAIT_STATES. If WAIT_STATES=0 it goes directly to OKAY_DONE behaviour in the first data cycle.
  - WAIT: hreadyout=0, hresp=0, counter decrements. When the counter reaches 0 the next cycle is OKAY_DONE.
  - OKAY_DONE: hreadyout=1, hresp=0; the data phase completes on this edge.
  - IDLE, illegal capture: goes to ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1). No memory access occurs.
  - Any state: on a completing edge where a new capture occurs, the FSM re-enters the appropriate state. This gives back-to-back transfers with no bubble.
- Write commit: only at the edge that completes an OKAY write data phase (hreadyout=1).
  - Byte lanes are selected by hsize and haddr[1:0], little-endian: byte lane = addr[1:0]; half lanes are [15:0] or [31:16].
  - Unselected bytes are unchanged.
- Read data:
  - hrdata = full word mem[addr>>2], driven while hreadyout=1 in the OKAY read data phase.
  - hrdata=0 in every other cycle, including ERROR cycles.
  - Sub-word reads return the full word; the master selects the lanes.
- Read-after-write to the same address, back-to-back: the read returns the newly written data, because the write commits before the read's data phase.
- Sampling during stall: address-phase signals presented while hreadyout=0 are not captured; capture requires hready=1.
- Mid-transfer reset: the transfer is abandoned and a pending write is not committed.

Decomposition:
- ahb_pkg holds:
  - htrans_e (IDLE/BUSY/NONSEQ/SEQ);
  - hsize_e;
  - HRESP_OKAY/HRESP_ERROR constants;
  - slave FSM state enum (sram_state_e).
- Sub-module ahb_sram_lane_mask: combinational hsize + addr[1:0] to 4-bit byte-enable, plus the alignment-error flag.
- The top level holds the FSM, wait counter, pipeline registers and the array.

Test Plan:
- Word write 0xDEADBEEF to 0x10, then read 0x10 with WAIT_STATES=1 -> each data phase has exactly 1 hreadyout=0 cycle; hrdata=0xDEADBEEF with hresp=0.
- Byte writes 0x11, 0x22, 0x33, 0x44 to 0x20..0x23, then word read 0x20 -> hrdata=0x44332211. Half write 0xABCD to 0x22, then read -> hrdata=0xABCD2211.
- Word read at 0x402 (misaligned) and at 0x400 (out of range, MEM_DEPTH=256) -> each gives hreadyout=0/hresp=1, then hreadyout=1/hresp=1; memory unchanged; hrdata=0.
- Pipelined NONSEQ write 0x5 to 0x8, immediately followed by SEQ read 0x8, WAIT_STATES=0 -> no bubble; read data phase hrdata=0x00000005.
- IDLE, BUSY and hsel=0 transfers -> hreadyout stays 1, hresp=0, no memory change.
- Assert hresetn=0 during the WAIT of a write to 0x30 (previously 0x0) -> outputs go to reset values immediately; a later read of 0x30 returns 0x0.
